// File: rtl/fetch1.sv
// Fetch stage: PC register, 8-byte pair fetch address, direct-mapped BTB with
// 2-bit counters, and sideband registered to line up with instruction memory data.
module fetch1 #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        btb_wr_i,
    input  logic [31:0] btb_wr_pc_i,
    input  logic [31:0] btb_wr_target_i,
    input  logic        btb_wr_taken_i,
    output logic [31:0] iaddr_o,
    output logic [31:0] pc0_o,
    output logic [31:0] pc1_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic        bubble_0_o,
    output logic        bubble_1_o
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;
    localparam logic [31:0] RESET_PAIR = {RESET_PC[31:3], 3'b000};

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic [31:0]   target;
        logic [1:0]    ctr;
    } btb_entry_t;

    btb_entry_t btb [BTB_ENTRIES];

    logic [31:0]   pc, pc_next, slot0_addr, slot1_addr, look_target;
    logic [IW-1:0] idx0, idx1, wr_idx;
    logic [TW-1:0] tag0, tag1, wr_tag;
    btb_entry_t    ent0, ent1, wr_ent;
    logic          take0, take1, look_taken, wr_hit;
    logic [1:0]    wr_ctr;
    logic          unused_low_bits;

    assign unused_low_bits = ^{pc[1:0], btb_wr_pc_i[1:0]};

    assign slot0_addr = {pc[31:3], 3'b000};
    assign slot1_addr = {pc[31:3], 3'b100};
    assign iaddr_o    = slot0_addr;

    assign idx0 = slot0_addr[IW+1:2];
    assign idx1 = slot1_addr[IW+1:2];
    assign tag0 = slot0_addr[31:IW+2];
    assign tag1 = slot1_addr[31:IW+2];
    assign ent0 = btb[idx0];
    assign ent1 = btb[idx1];

    // Slot 0 is not part of the fetch when entering the pair at its upper word.
    assign take0 = ~pc[2] & ent0.valid & (ent0.tag == tag0) & ent0.ctr[1];
    assign take1 = ent1.valid & (ent1.tag == tag1) & ent1.ctr[1];
    assign look_taken  = take0 | take1;
    assign look_target = take0 ? ent0.target : (take1 ? ent1.target : 32'h0);

    always_comb begin
        pc_next = slot0_addr + 32'd8;
        if (look_taken) pc_next = look_target;
    end

    assign wr_idx = btb_wr_pc_i[IW+1:2];
    assign wr_tag = btb_wr_pc_i[31:IW+2];
    assign wr_ent = btb[wr_idx];
    assign wr_hit = wr_ent.valid & (wr_ent.tag == wr_tag);

    always_comb begin
        wr_ctr = btb_wr_taken_i ? 2'b10 : 2'b01;
        if (wr_hit) begin
            if (btb_wr_taken_i) wr_ctr = (wr_ent.ctr == 2'b11) ? 2'b11 : wr_ent.ctr + 2'b01;
            else                wr_ctr = (wr_ent.ctr == 2'b00) ? 2'b00 : wr_ent.ctr - 2'b01;
        end
    end

    // Lookups above read the array combinationally, so a same-cycle write is seen next cycle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
        end else if (btb_wr_i) begin
            btb[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: btb_wr_target_i, ctr: wr_ctr};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc            <= RESET_PC;
            pc0_o         <= RESET_PAIR;
            pc1_o         <= RESET_PAIR + 32'd4;
            pred_taken_o  <= 1'b0;
            pred_target_o <= 32'h0;
            bubble_0_o    <= 1'b0;
            bubble_1_o    <= 1'b0;
        end else if (redirect_i) begin
            pc            <= redirect_pc_i;
            pc0_o         <= slot0_addr;
            pc1_o         <= slot1_addr;
            pred_taken_o  <= 1'b0;
            pred_target_o <= 32'h0;
            bubble_0_o    <= pc[2];
            bubble_1_o    <= 1'b0;
        end else if (!stall_i) begin
            pc            <= pc_next;
            pc0_o         <= slot0_addr;
            pc1_o         <= slot1_addr;
            pred_taken_o  <= look_taken;
            pred_target_o <= look_target;
            bubble_0_o    <= pc[2];
            bubble_1_o    <= take0;
        end
    end
endmodule

// File: tb/tb_fetch1.sv
// Bench for fetch1: directed vector table for the named scenarios, then random
// traffic checked against a behavioural model of the fetch/BTB rules.
module tb_fetch1;
    localparam int          N      = 16;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clock_i = 1'b0;
    logic        reset_i, stall_i, redirect_i, btb_wr_i, btb_wr_taken_i;
    logic [31:0] redirect_pc_i, btb_wr_pc_i, btb_wr_target_i;
    logic [31:0] iaddr_o, pc0_o, pc1_o, pred_target_o;
    logic        pred_taken_o, bubble_0_o, bubble_1_o;

    always #5 clock_i = ~clock_i;

    fetch1 #(.RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .btb_wr_i(btb_wr_i), .btb_wr_pc_i(btb_wr_pc_i),
        .btb_wr_target_i(btb_wr_target_i), .btb_wr_taken_i(btb_wr_taken_i),
        .iaddr_o(iaddr_o), .pc0_o(pc0_o), .pc1_o(pc1_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .bubble_0_o(bubble_0_o), .bubble_1_o(bubble_1_o)
    );

    typedef struct {
        logic rst, stall, redir; logic [31:0] rpc;
        logic wr; logic [31:0] wpc, wtgt; logic wtk;
        logic [31:0] e_ia, e_pc0; logic e_tk; logic [31:0] e_tgt; logic e_b0, e_b1;
    } vec_t;
    vec_t vt[$];

    int compared = 0, mismatched = 0;

    // Model state: architectural PC, registered sideband, and BTB keyed by word index.
    logic [31:0] m_pc, m_pc0, m_tgt;
    logic        m_tk, m_b0, m_b1;
    bit          m_v   [N];
    int unsigned m_tag [N];
    logic [31:0] m_bt  [N];
    int          m_ctr [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_lookup(input logic [31:0] a, output bit tk, output logic [31:0] t);
        int unsigned ix;
        ix = (a / 4) % N;
        tk = m_v[ix] && (m_tag[ix] == a / (4 * N)) && (m_ctr[ix] >= 2);
        t  = m_bt[ix];
    endtask

    task automatic model_step();
        logic [31:0] a0, t0, t1;
        bit p0, p1;
        int unsigned ix;
        if (reset_i) begin
            m_pc = RST_PC; m_pc0 = RST_PC & ~32'd7;
            m_tk = 0; m_tgt = 0; m_b0 = 0; m_b1 = 0;
            for (int i = 0; i < N; i++) begin m_v[i] = 0; m_ctr[i] = 0; end
            return;
        end
        a0 = m_pc & ~32'd7;
        m_lookup(a0, p0, t0);
        m_lookup(a0 + 4, p1, t1);
        if (m_pc[2]) p0 = 0;
        if (redirect_i) begin
            m_pc0 = a0; m_tk = 0; m_tgt = 0; m_b0 = m_pc[2]; m_b1 = 0;
            m_pc = redirect_pc_i;
        end else if (!stall_i) begin
            m_pc0 = a0; m_tk = p0 | p1; m_b0 = m_pc[2]; m_b1 = p0;
            m_tgt = p0 ? t0 : (p1 ? t1 : 32'h0);
            m_pc  = m_tk ? m_tgt : a0 + 8;
        end
        if (btb_wr_i) begin
            ix = (btb_wr_pc_i / 4) % N;
            if (m_v[ix] && m_tag[ix] == btb_wr_pc_i / (4 * N))
                m_ctr[ix] = btb_wr_taken_i ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                           : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
            else
                m_ctr[ix] = btb_wr_taken_i ? 2 : 1;
            m_v[ix] = 1; m_tag[ix] = btb_wr_pc_i / (4 * N); m_bt[ix] = btb_wr_target_i;
        end
    endtask

    task automatic cycle(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic wr, input logic [31:0] wpc, input logic [31:0] wtgt, input logic wtk);
        reset_i = rst; stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
        btb_wr_i = wr; btb_wr_pc_i = wpc; btb_wr_target_i = wtgt; btb_wr_taken_i = wtk;
        model_step();
        @(posedge clock_i);
        #1;
    endtask

    function automatic void v(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                              input logic wr, input logic [31:0] wpc, input logic [31:0] wtgt, input logic wtk,
                              input logic [31:0] ia, input logic [31:0] p0, input logic tk,
                              input logic [31:0] tg, input logic b0, input logic b1);
        vec_t r;
        r.rst = rst; r.stall = stall; r.redir = redir; r.rpc = rpc;
        r.wr = wr; r.wpc = wpc; r.wtgt = wtgt; r.wtk = wtk;
        r.e_ia = ia; r.e_pc0 = p0; r.e_tk = tk; r.e_tgt = tg; r.e_b0 = b0; r.e_b1 = b1;
        vt.push_back(r);
    endfunction

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return $urandom() & 32'hFFFF_FFFC;
        return {23'd0, 7'($urandom_range(0, 127)), 2'b00};
    endfunction

    initial begin
        reset_i = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        btb_wr_i = 0; btb_wr_pc_i = 0; btb_wr_target_i = 0; btb_wr_taken_i = 0;

        //  rst st rd rpc            wr wpc      wtgt     tk   iaddr          pc0            tk tgt       b0 b1
        v(1, 0, 0, 0,              0, 0,       0,       0,   32'h0,         32'h0,         0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h8,         32'h0,         0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h10,        32'h8,         0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  1,   32'h18,        32'h10,        0, 0,        0, 0);
        v(0, 0, 1, 32'h10,         0, 0,       0,       0,   32'h10,        32'h18,        0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h40,        32'h10,        1, 32'h40,   0, 1);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  0,   32'h48,        32'h40,        0, 0,        0, 0);
        v(0, 0, 1, 32'h10,         0, 0,       0,       0,   32'h10,        32'h48,        0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h18,        32'h10,        0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  1,   32'h20,        32'h18,        0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  1,   32'h28,        32'h20,        0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  1,   32'h30,        32'h28,        0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  1,   32'h38,        32'h30,        0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h10,  32'h40,  0,   32'h40,        32'h38,        0, 0,        0, 0);
        v(0, 0, 1, 32'h10,         0, 0,       0,       0,   32'h10,        32'h40,        0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h40,        32'h10,        1, 32'h40,   0, 1);
        v(0, 1, 1, 32'h104,        0, 0,       0,       0,   32'h100,       32'h40,        0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h108,       32'h100,       0, 0,        1, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h110,       32'h108,       0, 0,        0, 0);
        v(0, 1, 0, 0,              0, 0,       0,       0,   32'h110,       32'h108,       0, 0,        0, 0);
        v(0, 1, 0, 0,              0, 0,       0,       0,   32'h110,       32'h108,       0, 0,        0, 0);
        v(0, 1, 0, 0,              0, 0,       0,       0,   32'h110,       32'h108,       0, 0,        0, 0);
        v(0, 0, 0, 0,              1, 32'h11C, 32'h200, 1,   32'h118,       32'h110,       0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h200,       32'h118,       1, 32'h200,  0, 0);
        v(0, 1, 0, 0,              0, 0,       0,       0,   32'h200,       32'h118,       1, 32'h200,  0, 0);
        v(1, 1, 1, 32'h500,        1, 32'h200, 32'h300, 1,   32'h0,         32'h0,         0, 0,        0, 0);
        v(0, 0, 1, 32'h10,         0, 0,       0,       0,   32'h10,        32'h0,         0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h18,        32'h10,        0, 0,        0, 0);
        v(0, 0, 1, 32'h118,        0, 0,       0,       0,   32'h118,       32'h18,        0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h120,       32'h118,       0, 0,        0, 0);
        v(0, 0, 1, 32'h200,        0, 0,       0,       0,   32'h200,       32'h120,       0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h208,       32'h200,       0, 0,        0, 0);
        v(0, 0, 1, 32'hFFFF_FFF8,  0, 0,       0,       0,   32'hFFFF_FFF8, 32'h208,       0, 0,        0, 0);
        v(0, 0, 0, 0,              0, 0,       0,       0,   32'h0,         32'hFFFF_FFF8, 0, 0,        0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].rpc,
                  vt[i].wr, vt[i].wpc, vt[i].wtgt, vt[i].wtk);
            chk($sformatf("vec%0d iaddr", i), iaddr_o, vt[i].e_ia);
            chk($sformatf("vec%0d pc0", i), pc0_o, vt[i].e_pc0);
            chk($sformatf("vec%0d pc1", i), pc1_o, vt[i].e_pc0 + 32'd4);
            chk($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken_o}, {31'd0, vt[i].e_tk});
            chk($sformatf("vec%0d pred_target", i), pred_target_o, vt[i].e_tgt);
            chk($sformatf("vec%0d bubble_0", i), {31'd0, bubble_0_o}, {31'd0, vt[i].e_b0});
            chk($sformatf("vec%0d bubble_1", i), {31'd0, bubble_1_o}, {31'd0, vt[i].e_b1});
        end

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  pick_addr(), $urandom_range(0, 2) == 0, pick_addr(), pick_addr(),
                  $urandom_range(0, 3) != 0);
            chk($sformatf("rnd%0d iaddr", c), iaddr_o, m_pc & ~32'd7);
            chk($sformatf("rnd%0d pc0", c), pc0_o, m_pc0);
            chk($sformatf("rnd%0d pc1", c), pc1_o, m_pc0 + 32'd4);
            chk($sformatf("rnd%0d pred_taken", c), {31'd0, pred_taken_o}, {31'd0, m_tk});
            chk($sformatf("rnd%0d pred_target", c), pred_target_o, m_tgt);
            chk($sformatf("rnd%0d bubble_0", c), {31'd0, bubble_0_o}, {31'd0, m_b0});
            chk($sformatf("rnd%0d bubble_1", c), {31'd0, bubble_1_o}, {31'd0, m_b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
